// File: rtl/run_pkg.sv
// Shared constants for the run-sequencing controller: FSM encodings and default widths.
package run_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_CLEAR   = 3'd1;
    localparam state_t ST_RUN     = 3'd2;
    localparam state_t ST_DONE    = 3'd3;
    localparam state_t ST_TIMEOUT = 3'd4;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_DONE_PC = 190;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/run_ctrl_mem_port_mux.sv
// Data-memory port mux: owner=1 routes the host request, owner=0 routes the core request.
module mem_port_mux #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              owner,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);

    assign mem_we    = owner ? host_we    : core_we;
    assign mem_addr  = owner ? host_addr  : core_addr;
    assign mem_wdata = owner ? host_wdata : core_wdata;

endmodule

// File: rtl/run_ctrl.sv
// Run-sequencing controller: start edge -> core reset window -> run until DONE_PC, with
// data-memory port arbitration. Define RUN_WDOG_EN to enable the MAX_CYCLES watchdog.
module run_ctrl
    import run_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DONE_PC    = DEF_DONE_PC,
    parameter int RST_CYCLES = 2,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MAX_CYCLES = 16'hFFF0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc,
    output logic              core_rst,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [2:0]        fsm_state
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam logic [RC_W-1:0]  RC_LAST   = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(MAX_CYCLES - 1);

`ifdef RUN_WDOG_EN
    localparam logic WDOG_EN = 1'b1;
`else
    localparam logic WDOG_EN = 1'b0;
`endif

    state_t          state;
    logic            start_q;
    logic            start_rise;
    logic [RC_W-1:0] rst_cnt;
    logic            pc_match;
    logic            wdog_hit;
    logic            port_free;
    logic            core_we_eff;
    logic            host_we_eff;

    assign start_rise = start & ~start_q;
    assign pc_match   = (pc == ADDR_W'(DONE_PC));
    assign wdog_hit   = WDOG_EN & (cycle_count == WDOG_LAST);
    assign fsm_state  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            start_q     <= 1'b0;
            cycle_count <= '0;
            rst_cnt     <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            start_q <= start;
            case (state)
                ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                    if (start_rise) begin
                        state       <= ST_CLEAR;
                        rst_cnt     <= '0;
                        cycle_count <= '0;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    rst_cnt <= rst_cnt + 1'b1;
                    if (rst_cnt == RC_LAST) state <= ST_RUN;
                end
                ST_RUN: begin
                    // The completing cycle is counted too; a PC match beats the watchdog.
                    if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
                    if (pc_match) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (wdog_hit) begin
                        state   <= ST_TIMEOUT;
                        timeout <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign core_rst = rst | (state != ST_RUN);

    // Host handshake: host_req is held until host_gnt is seen; a write happens only in a
    // cycle with host_req & host_gnt & host_we. Nothing is queued while the core runs.
    assign port_free   = (state == ST_IDLE) | (state == ST_DONE) | (state == ST_TIMEOUT);
    assign host_gnt    = host_req & port_free;
    assign host_we_eff = host_we & ~rst;
    assign core_we_eff = core_we & (state == ST_RUN) & ~rst;

    mem_port_mux #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mux (
        .owner      (host_gnt),
        .host_we    (host_we_eff),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .core_we    (core_we_eff),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata)
    );

endmodule
